ex_muldiv: RTL and testbench

//  EX-stage multiply/divide unit with architectural HI/LO registers. Consumes the

---
 rtl/ex_muldiv_if.sv | 24 ++
 rtl/ex_muldiv.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Signals between the ID/EX pipeline register and the EX-stage multiply/divide unit.
// An EX instruction retires on a rising clk edge where md_stall=0; while md_stall=1 the
// master holds ex_opcode/ex_func/ex_rdata_a/ex_rdata_b stable and the slave keeps working.
interface ex_muldiv_if;
   logic [5:0]  ex_opcode;
   logic [5:0]  ex_func;
   logic [31:0] ex_rdata_a;
   logic [31:0] ex_rdata_b;
   logic        md_stall;
   logic [31:0] md_rdata;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic [1:0]  md_state;

   modport master (
      output ex_opcode, ex_func, ex_rdata_a, ex_rdata_b,
      input  md_stall, md_rdata, md_hi, md_lo, md_state
   );

   modport slave (
      input  ex_opcode, ex_func, ex_rdata_a, ex_rdata_b,
      output md_stall, md_rdata, md_hi, md_lo, md_state
   );
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with HI/LO registers: multi-cycle MULT/MULTU,
// 32-step restoring DIV/DIVU, and MFHI/MFLO/MTHI/MTLO.
module ex_muldiv #(
   parameter int MUL_LAT = 2
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave md
);
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [31:0] hi, lo;
   logic [32:0] mul_a, mul_b;
   logic [63:0] rq;
   logic [31:0] dvsr;
   logic        q_neg, r_neg;

   logic        is_r, op_mul, op_div, op_signed, div_zero;
   logic        mul_last, div_last;
   logic [31:0] abs_a, abs_b;
   logic signed [63:0] prod;
   logic [32:0] shl;
   logic        q_bit;
   logic [31:0] rem_nxt;
   logic [63:0] rq_nxt;
   logic [31:0] q_fin, r_fin;

   assign is_r      = (md.ex_opcode == 6'b000000);
   assign op_mul    = is_r && (md.ex_func == F_MULT || md.ex_func == F_MULTU);
   assign op_div    = is_r && (md.ex_func == F_DIV || md.ex_func == F_DIVU);
   assign op_signed = (md.ex_func == F_MULT) || (md.ex_func == F_DIV);
   assign div_zero  = (md.ex_rdata_b == 32'd0);
   assign mul_last  = (cnt == 6'(MUL_LAT - 1));
   assign div_last  = (cnt == 6'd31);

   assign abs_a = (op_signed && md.ex_rdata_a[31]) ? -md.ex_rdata_a : md.ex_rdata_a;
   assign abs_b = (op_signed && md.ex_rdata_b[31]) ? -md.ex_rdata_b : md.ex_rdata_b;

   // Operands are latched 33 bits wide so one signed multiply covers both MULT and MULTU.
   assign prod = $signed(mul_a) * $signed(mul_b);

   // Partial remainder can reach 33 bits after the shift when the divisor exceeds 2^31.
   assign shl     = rq[63:31];
   assign q_bit   = (shl >= {1'b0, dvsr});
   assign rem_nxt = q_bit ? (shl[31:0] - dvsr) : shl[31:0];
   assign rq_nxt  = {rem_nxt, rq[30:0], q_bit};
   assign q_fin   = q_neg ? -rq_nxt[31:0] : rq_nxt[31:0];
   assign r_fin   = r_neg ? -rq_nxt[63:32] : rq_nxt[63:32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (op_mul)      state_nxt = MUL;
            else if (op_div) state_nxt = div_zero ? DONE : DIV;
         end
         MUL:     if (mul_last) state_nxt = DONE;
         DIV:     if (div_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      md.md_stall = 1'b0;
      case (state)
         IDLE:    md.md_stall = op_mul || op_div;
         MUL:     md.md_stall = 1'b1;
         DIV:     md.md_stall = 1'b1;
         default: md.md_stall = 1'b0;
      endcase
      // Stall drops as soon as reset asserts, even with a mul/div sitting in EX.
      if (!rst) md.md_stall = 1'b0;

      md.md_rdata = 32'd0;
      if (is_r && md.ex_func == F_MFHI)      md.md_rdata = hi;
      else if (is_r && md.ex_func == F_MFLO) md.md_rdata = lo;

      md.md_hi    = hi;
      md.md_lo    = lo;
      md.md_state = state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= 6'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         mul_a <= 33'd0;
         mul_b <= 33'd0;
         rq    <= 64'd0;
         dvsr  <= 32'd0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= 6'd0;
               if (op_mul) begin
                  mul_a <= {op_signed & md.ex_rdata_a[31], md.ex_rdata_a};
                  mul_b <= {op_signed & md.ex_rdata_b[31], md.ex_rdata_b};
               end else if (op_div) begin
                  if (div_zero) begin
                     lo <= 32'hFFFF_FFFF;
                     hi <= md.ex_rdata_a;
                  end else begin
                     rq    <= {32'd0, abs_a};
                     dvsr  <= abs_b;
                     q_neg <= op_signed & (md.ex_rdata_a[31] ^ md.ex_rdata_b[31]);
                     r_neg <= op_signed & md.ex_rdata_a[31];
                  end
               end else if (is_r && md.ex_func == F_MTHI) begin
                  hi <= md.ex_rdata_a;
               end else if (is_r && md.ex_func == F_MTLO) begin
                  lo <= md.ex_rdata_a;
               end
            end
            MUL: begin
               cnt <= cnt + 6'd1;
               if (mul_last) {hi, lo} <= prod;
            end
            DIV: begin
               cnt <= cnt + 6'd1;
               rq  <= rq_nxt;
               if (div_last) begin
                  lo <= q_fin;
                  hi <= r_fin;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a driver holds each instruction in EX until it retires,
// a monitor pops the expected stall count / read data / HI-LO at every retirement.
module tb_ex_muldiv;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam int EW = 106;

   logic clk = 1'b0;
   logic rst = 1'b0;
   ex_muldiv_if md_if ();

   ex_muldiv #(.MUL_LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md_if)
   );

   always #5 clk = ~clk;

   // Entry: {stall[7:0], chk_rd, rd[31:0], chk_hl, hi[31:0], lo[31:0]}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] e;
   int   total = 0;
   int   bad = 0;
   int   stall_cnt = 0;
   logic ex_valid = 1'b0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic push_exp(input int stall, input bit chk_rd, input logic [31:0] rd,
                           input bit chk_hl, input logic [31:0] hi, input logic [31:0] lo);
      exp_q.push_back({8'(stall), chk_rd, rd, chk_hl, hi, lo});
   endtask

   task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      int budget;
      md_if.ex_opcode  = opc;
      md_if.ex_func    = fn;
      md_if.ex_rdata_a = a;
      md_if.ex_rdata_b = b;
      ex_valid = 1'b1;
      budget = 0;
      forever begin
         @(negedge clk);
         if (!md_if.md_stall) break;
         budget++;
         if (budget > 200) begin
            total++;
            bad++;
            $display("FAIL timeout func=%h stall still high after %0d cycles", fn, budget);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input int stall, input logic [31:0] hi, input logic [31:0] lo);
      push_exp(stall, 1'b1, 32'd0, 1'b1, hi, lo);
      issue(6'd0, fn, a, b);
   endtask

   task automatic mf(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rd);
      push_exp(0, 1'b1, rd, 1'b0, 32'd0, 32'd0);
      issue(opc, fn, 32'h1111_1111, 32'h2222_2222);
   endtask

   task automatic mt(input logic [5:0] fn, input logic [31:0] a);
      push_exp(0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
      issue(6'd0, fn, a, 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en && ex_valid && rst) begin
         if (md_if.md_stall) begin
            stall_cnt++;
         end else begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_retire func=%h t=%0t", md_if.ex_func, $time);
            end else begin
               e = exp_q.pop_front();
               chk("stall_cycles", 32'(stall_cnt), 32'(e[105:98]));
               if (e[97]) chk("md_rdata", md_if.md_rdata, e[96:65]);
               if (e[64]) begin
                  chk("md_hi", md_if.md_hi, e[63:32]);
                  chk("md_lo", md_if.md_lo, e[31:0]);
               end
            end
            stall_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      md_if.ex_opcode  = 6'd0;
      md_if.ex_func    = F_MFHI;
      md_if.ex_rdata_a = 32'd0;
      md_if.ex_rdata_b = 32'd0;
      #1;
      chk("rst_stall", {31'd0, md_if.md_stall}, 32'd0);
      chk("rst_rdata", md_if.md_rdata, 32'd0);
      chk("rst_hi", md_if.md_hi, 32'd0);
      chk("rst_lo", md_if.md_lo, 32'd0);
      chk("rst_state", {30'd0, md_if.md_state}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      mdu(F_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mdu(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001);
      mdu(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'h0000_0000, 32'h0000_0001);
      mdu(F_MULT, 32'hFFFF_FFFD, 32'd5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      mdu(F_DIVU, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF);
      mt(F_MTHI, 32'hA5A5_A5A5);
      mf(6'd0, F_MFHI, 32'hA5A5_A5A5);
      mt(F_MTLO, 32'h5A5A_5A5A);
      mf(6'd0, F_MFLO, 32'h5A5A_5A5A);
      mf(6'h23, F_MFHI, 32'd0);
      mf(6'h08, F_MULT, 32'd0);
      mf(6'd0, F_MFHI, 32'hA5A5_A5A5);
      mdu(F_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      mdu(F_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);
      mdu(F_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
      mdu(F_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32'h7FFF_FFFF, 32'd1);
      mdu(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
      mf(6'd0, F_MFLO, 32'h8000_0000);

      // Abort a divide part-way through with an asynchronous reset.
      mon_en   = 1'b0;
      ex_valid = 1'b0;
      md_if.ex_opcode  = 6'd0;
      md_if.ex_func    = F_DIV;
      md_if.ex_rdata_a = 32'd100;
      md_if.ex_rdata_b = 32'd7;
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("abort_stall", {31'd0, md_if.md_stall}, 32'd0);
      chk("abort_hi", md_if.md_hi, 32'd0);
      chk("abort_lo", md_if.md_lo, 32'd0);
      chk("abort_state", {30'd0, md_if.md_state}, 32'd0);
      md_if.ex_func = F_MFLO;
      #1;
      chk("abort_rdata", md_if.md_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_state", {30'd0, md_if.md_state}, 32'd0);
      chk("post_rst_stall", {31'd0, md_if.md_stall}, 32'd0);
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      mf(6'd0, F_MFLO, 32'd0);
      mf(6'd0, F_MFHI, 32'd0);
      mdu(F_MULTU, 32'd6, 32'd7, 3, 32'd0, 32'd42);

      ex_valid = 1'b0;
      md_if.ex_func = 6'd0;
      repeat (3) @(posedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
